// File: rtl/fp32_mul_issue.sv
// FP32 multiply issue stage: latches an operand pair, starts the multiplier core,
// waits for done (with timeout), then holds the product and flags until downstream takes them.
module fp32_mul_issue #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        mul_start_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [31:0] mul_product_i,
    input  logic        mul_done_i,
    input  logic        mul_nan_i,
    input  logic        mul_inf_i,
    input  logic        mul_ovf_i,
    input  logic        mul_udf_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_product,
    output logic [4:0]  out_flags,
    output logic [7:0]  op_count
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_armed;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [3:0]    r_sticky;
    logic [CW-1:0] r_wcnt;
    logic [31:0]   r_prod;
    logic [4:0]    r_flags;
    logic [7:0]    r_cnt;

    logic          w_accept;
    logic          w_in_wait;
    logic          w_done;
    logic          w_tmo;
    logic [3:0]    w_cur;

    assign w_cur     = {mul_nan_i, mul_inf_i, mul_ovf_i, mul_udf_i};
    assign w_in_wait = (r_state == S_WAIT);
    assign w_accept  = in_valid & in_ready;
    assign w_done    = w_in_wait & mul_done_i;
    assign w_tmo     = w_in_wait & ~mul_done_i
                     & (r_wcnt == CW'(TIMEOUT - 1));

    // r_armed keeps in_ready low until the first edge after reset release
    assign in_ready    = r_armed & (r_state == S_IDLE);
    assign mul_start_o = (r_state == S_ISSUE);
    assign out_valid   = (r_state == S_HOLD);
    assign mul_a_o     = r_a;
    assign mul_b_o     = r_b;
    assign out_product = r_prod;
    assign out_flags   = r_flags;
    assign op_count    = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_done || w_tmo) w_next = S_HOLD;
            S_HOLD:  if (out_ready) w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sticky <= '0;
            r_wcnt   <= '0;
            r_prod   <= '0;
            r_flags  <= '0;
            r_cnt    <= '0;
        end else begin
            r_armed <= 1'b1;
            if (w_accept) begin
                r_a      <= in_a;
                r_b      <= in_b;
                r_sticky <= '0;
            end
            // flags may pulse before done, so accumulate every WAIT cycle
            if (r_state == S_ISSUE) begin
                r_wcnt <= '0;
            end else if (w_in_wait) begin
                r_wcnt   <= r_wcnt + CW'(1);
                r_sticky <= r_sticky | w_cur;
            end
            if (w_done) begin
                r_prod  <= mul_product_i;
                r_flags <= {1'b0, r_sticky | w_cur};
                r_cnt   <= r_cnt + 8'd1;
            end else if (w_tmo) begin
                r_prod  <= 32'h7FC0_0000;
                r_flags <= 5'b10000;
            end
        end
    end

endmodule

// File: tb/tb_fp32_mul_issue.sv
// Bench for fp32_mul_issue: behavioural 4-state multiplier core,
// vector table and scoreboard queue, plus backpressure/timeout/reset sequences.
module tb_fp32_mul_issue;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
        logic [3:0]  fl;
        int          lead;
        bit          nodone;
        int          lat;
        logic [31:0] eprod;
        logic [4:0]  eflags;
    } vec_t;

    typedef struct {
        logic [31:0] prod;
        logic [4:0]  fl;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_ready;
    logic        mul_start_o;
    logic [31:0] mul_a_o;
    logic [31:0] mul_b_o;
    logic [31:0] mul_product_i;
    logic        mul_done_i;
    logic        mul_nan_i;
    logic        mul_inf_i;
    logic        mul_ovf_i;
    logic        mul_udf_i;
    logic        out_valid;
    logic [31:0] out_product;
    logic [4:0]  out_flags;
    logic [7:0]  op_count;

    logic [31:0] core_prod = '0;
    logic [3:0]  core_fl = '0;
    int          core_lead = 0;
    bit          core_nodone = 1'b0;
    logic        core_done;
    logic [3:0]  core_flags;
    int          ph;
    logic        extra_done = 1'b0;
    logic        extra_nan = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_cnt = '0;
    exp_t        q[$];
    vec_t        vecs[7];

    assign mul_product_i = core_prod;
    assign mul_done_i    = core_done | extra_done;
    assign mul_nan_i     = core_flags[3] | extra_nan;
    assign mul_inf_i     = core_flags[2];
    assign mul_ovf_i     = core_flags[1];
    assign mul_udf_i     = core_flags[0];

    fp32_mul_issue #(.TIMEOUT(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .mul_start_o(mul_start_o),
        .mul_a_o(mul_a_o),
        .mul_b_o(mul_b_o),
        .mul_product_i(mul_product_i),
        .mul_done_i(mul_done_i),
        .mul_nan_i(mul_nan_i),
        .mul_inf_i(mul_inf_i),
        .mul_ovf_i(mul_ovf_i),
        .mul_udf_i(mul_udf_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_product(out_product),
        .out_flags(out_flags),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Core model: start seen in cycle N+1, done driven in cycle N+4
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0;
            core_done = 1'b0;
            core_flags = '0;
        end else begin
            if (mul_start_o) ph = 1;
            else if (ph != 0 && ph < 4) ph = ph + 1;
            else ph = 0;
            core_done = (ph == 4) && !core_nodone;
            core_flags = (ph != 0 && ph == 4 - core_lead) ? core_fl : 4'h0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_start"}, 32'(mul_start_o), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_mul_a"}, mul_a_o, 32'd0);
        chk({tag, "_mul_b"}, mul_b_o, 32'd0);
        chk({tag, "_product"}, out_product, 32'd0);
        chk({tag, "_flags"}, 32'(out_flags), 32'd0);
        chk({tag, "_op_count"}, 32'(op_count), 32'd0);
    endtask

    task automatic do_op(input vec_t v, input int hold);
        exp_t e;
        int k, st, n;
        logic opnd;
        core_prod = v.prod;
        core_fl = v.fl;
        core_lead = v.lead;
        core_nodone = v.nodone;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a = v.a;
        in_b = v.b;
        if (!v.nodone) exp_cnt = exp_cnt + 8'd1;
        e.prod = v.eprod;
        e.fl = v.eflags;
        e.cnt = exp_cnt;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        st = 0;
        n = 0;
        opnd = 1'b0;
        while (!out_valid && k < 40) begin
            if (mul_start_o) begin
                n++;
                if (st == 0) begin
                    st = k;
                    opnd = (mul_a_o == v.a) && (mul_b_o == v.b);
                end
            end
            @(negedge clk);
            k++;
        end
        chk("start_cycle", 32'(st), 32'd1);
        chk("start_pulses", 32'(n), 32'd1);
        chk("operands", 32'(opnd), 32'd1);
        chk("latency", 32'(k), 32'(v.lat));
        if (q.size() == 0) begin
            chk("sb_empty", 32'(q.size()), 32'd1);
        end else begin
            e = q.pop_front();
            chk("product", out_product, e.prod);
            chk("flags", 32'(out_flags), 32'(e.fl));
            chk("op_count", 32'(op_count), 32'(e.cnt));
        end
        if (v.nodone) begin
            extra_done = 1'b1;
            extra_nan = 1'b1;
            @(negedge clk);
            extra_done = 1'b0;
            extra_nan = 1'b0;
            chk("late_hold_prod", out_product, e.prod);
            chk("late_hold_flags", 32'(out_flags), 32'(e.fl));
            chk("late_hold_cnt", 32'(op_count), 32'(e.cnt));
        end
        in_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_prod", out_product, e.prod);
            chk("bp_start", 32'(mul_start_o), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("no_reaccept", 32'(mul_start_o), 32'd0);
        if (v.nodone) begin
            extra_done = 1'b1;
            @(negedge clk);
            extra_done = 1'b0;
            chk("late_idle_cnt", 32'(op_count), 32'(e.cnt));
            chk("late_idle_valid", 32'(out_valid), 32'd0);
            chk("late_idle_flags", 32'(out_flags), 32'(e.fl));
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 0, 1'b0,
                    5, 32'h40C00000, 5'b00000};
        vecs[1] = '{32'h7FC00000, 32'h3F800000, 32'h00000000, 4'b1000, 2, 1'b0,
                    5, 32'h00000000, 5'b01000};
        vecs[2] = '{32'h7F800000, 32'h3F800000, 32'h7FFFFFFF, 4'b0100, 1, 1'b0,
                    5, 32'h7FFFFFFF, 5'b00100};
        vecs[3] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0010, 0, 1'b0,
                    5, 32'h7F800000, 5'b00010};
        vecs[4] = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0001, 1, 1'b0,
                    5, 32'h00000000, 5'b00001};
        vecs[5] = '{32'h3F800000, 32'h40000000, 32'h12345678, 4'b0000, 0, 1'b1,
                    18, 32'h7FC00000, 5'b10000};
        vecs[6] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 0, 1'b0,
                    5, 32'h3F800000, 5'b00000};

        repeat (3) @(negedge clk);
        chk_rst("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        for (int i = 0; i < 7; i++) do_op(vecs[i], 0);

        do_op(vecs[0], 10);

        // Reset while the operation sits in WAIT
        core_nodone = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_a = 32'h40000000;
        in_b = 32'h40400000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_rst("mid_reset");
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_reset", 32'(in_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("abandoned_no_output", 32'(n), 32'd0);

        for (int i = 0; i < 256; i++) do_op(vecs[i % 5], 0);
        chk("wrap_count", 32'(op_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp32_mul_issue.md
FP32_MUL_ISSUE -- requirements
Module: fp32_mul_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum cycles spent in WAIT before the operation is abandoned.
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have ports in_a, in_b  input  32 each  IEEE-754 single operands.
REQ-007 SHALL have ports mul_start_o  output  1, and mul_a_o, mul_b_o  output  32 each  multiplier core start pulse and operands.
REQ-008 SHALL have port mul_product_i  input  32  multiplier result.
REQ-009 SHALL have ports mul_done_i, mul_nan_i, mul_inf_i, mul_ovf_i, mul_udf_i  input  1 each  multiplier done and status flags.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_product  output  32  captured product.
REQ-013 SHALL have port out_flags  output  5  {timeout, nan, inf, ovf, udf}.
REQ-014 SHALL have port op_count  output  8  completed-operation counter.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> HOLD -> IDLE, with only these transitions plus reset.
REQ-016 in_ready SHALL be 1 only in IDLE; on in_valid & in_ready, in_a/in_b latch into internal registers and FSM goes to ISSUE.
REQ-017 mul_a_o/mul_b_o SHALL be driven from latched registers and remain stable from ISSUE until WAIT is exited.
REQ-018 mul_start_o SHALL be 1 for exactly the single ISSUE cycle and 0 in all other states.
REQ-019 Sticky flag register SHALL clear on acceptance and, each WAIT cycle, OR in mul_nan_i/inf_i/ovf_i/udf_i; the multiplier pulses flags one cycle before done_o, so flags are never sampled only at done.
REQ-020 On mul_done_i in WAIT: out_product <= mul_product_i, out_flags <= {0, sticky OR current-cycle flags}, op_count increments (255 wraps to 0), FSM -> HOLD.
REQ-021 Wait counter SHALL clear on entry to WAIT and increment each WAIT cycle; at TIMEOUT cycles without mul_done_i: out_product <= 32'h7FC00000, out_flags <= 5'b10000, op_count unchanged, FSM -> HOLD.
REQ-022 mul_done_i and flag inputs SHALL be ignored in IDLE, ISSUE and HOLD (late done after timeout has no effect).
REQ-023 In HOLD out_valid SHALL be 1 and out_product/out_flags stable; on out_ready FSM -> IDLE; no same-cycle acceptance of a new pair.
REQ-024 Latency with the 4-state multiplier core: accept cycle N, mul_start_o at N+1, mul_done_i at N+4, out_valid at N+5.
REQ-025 out_valid SHALL be 0 outside HOLD; out_product/out_flags SHALL hold last captured value outside HOLD.

Reset
REQ-026 While rst_n is 0: FSM IDLE; in_ready, mul_start_o, out_valid 0; mul_a_o, mul_b_o, out_product, out_flags, op_count, sticky flags, wait counter all 0.
REQ-027 in_ready SHALL rise in the first clock cycle after rst_n deasserts; reset mid-operation SHALL abandon it with no output produced.

Verification
REQ-028 in_a=0x40000000, in_b=0x40400000, core returns 0x40C00000 -> out_valid at N+5, out_product 0x40C00000, out_flags 5'b00000, op_count 1.
REQ-029 in_a=0x7FC00000, core pulses mul_nan_i two cycles before done, product 0 -> out_flags 5'b01000, out_product 0x00000000.
REQ-030 in_a=0x7F800000, in_b=0x3F800000, mul_inf_i one cycle before done -> out_flags 5'b00100, out_product 0x7FFFFFFF.
REQ-031 mul_done_i held 0 -> out_valid after 16 WAIT cycles, out_product 0x7FC00000, out_flags 5'b10000; done pulse afterwards changes nothing.
REQ-032 out_ready held 0 for 10 cycles in HOLD with in_valid=1 -> outputs stable, in_ready 0, no new pair accepted; 256 completions -> op_count 0.
REQ-033 rst_n asserted during WAIT -> all outputs 0 asynchronously, in_ready 1 the cycle after release.
